// File: rtl/cnn_fmap_streamer.sv
// Captures a full ROWSxCOLS feature map in one cycle and streams it out raster-order over valid/ready.
// Build with CNN_FMAP_ZERO_SKIP_EN defined to suppress zero-valued elements; otherwise every element is emitted.
module cnn_fmap_streamer #(
  parameter int DATA_W = 33,
  parameter int ROWS   = 11,
  parameter int COLS   = 11,
  localparam int N     = ROWS * COLS,
  localparam int IDX_W = $clog2(N),
  localparam int ROW_W = $clog2(ROWS),
  localparam int COL_W = $clog2(COLS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [N-1:0][DATA_W-1:0] fmap_in_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [IDX_W-1:0]         out_idx_o,
  output logic [ROW_W-1:0]         out_row_o,
  output logic [COL_W-1:0]         out_col_o,
  output logic                     out_last_o,
  output logic                     frame_done_o
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [N-1:0][DATA_W-1:0] buf_q;
  logic [DATA_W-1:0]        data_q, data_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic                     last_q, last_d;
  logic                     done_q, done_d;

  logic             cap, hs, hs_last, cap_any;
  logic [IDX_W-1:0] cap_first, cap_last_ref, run_last_ref, nxt_idx;
  logic [ROW_W-1:0] cap_row, nxt_row;
  logic [COL_W-1:0] cap_col, nxt_col;

  assign hs      = (state_q == STREAM) & out_ready_i;
  assign hs_last = hs & last_q;
  assign cap     = in_valid_i & in_ready_o;

`ifdef CNN_FMAP_ZERO_SKIP_EN
  logic [N-1:0]     nz_q;
  logic [IDX_W-1:0] lastnz_q;

  // Capture-side search works on the incoming frame, stream-side on the stored nonzero map.
  always_comb begin
    cap_any      = 1'b0;
    cap_first    = '0;
    cap_last_ref = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (fmap_in_i[i] != '0) begin
        cap_any   = 1'b1;
        cap_first = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (fmap_in_i[i] != '0) cap_last_ref = IDX_W'(i);
    end
    nxt_idx = idx_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (nz_q[i] && (i > int'(idx_q))) nxt_idx = IDX_W'(i);
    end
    cap_row = ROW_W'(int'(cap_first) / COLS);
    cap_col = COL_W'(int'(cap_first) % COLS);
    nxt_row = ROW_W'(int'(nxt_idx) / COLS);
    nxt_col = COL_W'(int'(nxt_idx) % COLS);
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      lastnz_q <= cap_last_ref;
      for (int i = 0; i < N; i++) nz_q[i] <= (fmap_in_i[i] != '0);
    end
  end

  assign run_last_ref = lastnz_q;
`else
  assign cap_any      = 1'b1;
  assign cap_first    = '0;
  assign cap_row      = '0;
  assign cap_col      = '0;
  assign cap_last_ref = IDX_W'(N - 1);
  assign run_last_ref = IDX_W'(N - 1);
  assign nxt_idx      = idx_q + IDX_W'(1);
  assign nxt_col      = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
  assign nxt_row      = (col_q == COL_W'(COLS - 1)) ? row_q + ROW_W'(1) : row_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) buf_q <= fmap_in_i;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cap && cap_any) state_d = STREAM;
      STREAM:  if (hs_last) state_d = (cap && cap_any) ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q == STREAM);
    in_ready_o  = (state_q == IDLE) | ((state_q == STREAM) & out_ready_i & last_q);
  end

  // Element registers hold their value through stalls and idle periods.
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    row_d  = row_q;
    col_d  = col_q;
    last_d = last_q;
    done_d = hs_last | (cap & ~cap_any);
    if (cap && cap_any) begin
      data_d = fmap_in_i[cap_first];
      idx_d  = cap_first;
      row_d  = cap_row;
      col_d  = cap_col;
      last_d = (cap_first == cap_last_ref);
    end else if (hs && !last_q) begin
      data_d = buf_q[nxt_idx];
      idx_d  = nxt_idx;
      row_d  = nxt_row;
      col_d  = nxt_col;
      last_d = (nxt_idx == run_last_ref);
    end
  end

  assign out_data_o   = data_q;
  assign out_idx_o    = idx_q;
  assign out_row_o    = row_q;
  assign out_col_o    = col_q;
  assign out_last_o   = last_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_cnn_fmap_streamer.sv
// Randomized bench for cnn_fmap_streamer; a queue-based frame model predicts every beat, in_ready and frame_done.
module tb_cnn_fmap_streamer;
  localparam int N = 121;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0][32:0] fmap = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [32:0]      out_data;
  logic [6:0]       out_idx;
  logic [3:0]       out_row, out_col;
  logic             out_last, frame_done;

  always #5 clk = ~clk;

  cnn_fmap_streamer dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .fmap_in_i   (fmap),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .out_row_o   (out_row),
    .out_col_o   (out_col),
    .out_last_o  (out_last),
    .frame_done_o(frame_done)
  );

  typedef struct {
    logic [32:0] d;
    int          idx;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0, n_err = 0;
  int    n_cap = 0, n_done_obs = 0;
  bit    model_on = 0, fresh = 0, exp_done = 0;
  int    rdy_mode = 0, stall_at = -1, stall_left = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [N-1:0][32:0] f, output int cnt);
    beat_t b;
    cnt = 0;
    for (int i = 0; i < N; i++) begin
`ifdef CNN_FMAP_ZERO_SKIP_EN
      if (f[i] == '0) continue;
`endif
      b.d = f[i]; b.idx = i; b.last = 0;
      exp_q.push_back(b);
      cnt++;
    end
    if (cnt > 0) begin
      b = exp_q.pop_back();
      b.last = 1;
      exp_q.push_back(b);
    end
  endtask

  // Compare the DUT against the model, then advance the model across the coming clock edge.
  task automatic monitor();
    bit busy, rdy_exp, nd;
    int cnt;
    beat_t b;
    busy    = exp_q.size() > 0;
    rdy_exp = !busy || (out_ready && exp_q[0].last);
    if (model_on) begin
      chk("out_valid", 64'(out_valid), 64'(busy));
      chk("in_ready", 64'(in_ready), 64'(rdy_exp));
      chk("frame_done", 64'(frame_done), 64'(exp_done));
      if (frame_done) n_done_obs++;
      if (busy) begin
        b = exp_q[0];
        chk("out_data", 64'(out_data), 64'(b.d));
        chk("out_idx", 64'(out_idx), 64'(b.idx));
        chk("out_row", 64'(out_row), 64'(b.idx / 11));
        chk("out_col", 64'(out_col), 64'(b.idx % 11));
        chk("out_last", 64'(out_last), 64'(b.last));
      end else if (fresh) begin
        chk("rst_idx", 64'(out_idx), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
      end
    end
    nd = 0;
    if (rst) begin
      model_on = 1;
      fresh    = 1;
      exp_q.delete();
    end else if (model_on) begin
      if (busy && out_ready) begin
        b = exp_q.pop_front();
        if (b.last) nd = 1;
      end
      if (in_valid && rdy_exp) begin
        n_cap++;
        fresh = 0;
        push_frame(fmap, cnt);
        if (cnt == 0) nd = 1;
      end
    end
    exp_done = nd;
  endtask

  task automatic drive_ready();
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else if (stall_at >= 0 && exp_q.size() > 0 && exp_q[0].idx == stall_at) begin
      out_ready  = 1'b0;
      stall_left = 4;
      stall_at   = -1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive_ready();
  endtask

  function automatic logic [N-1:0][32:0] rand_frame(input int zero_pct);
    logic [N-1:0][32:0] f;
    for (int i = 0; i < N; i++)
      f[i] = (int'($urandom_range(0, 99)) < zero_pct) ? 33'd0 : {1'($urandom_range(0, 1)), $urandom()};
    return f;
  endfunction

  function automatic logic [N-1:0][32:0] ramp_frame();
    logic [N-1:0][32:0] f;
    for (int i = 0; i < N; i++) f[i] = 33'(i - 60);
    return f;
  endfunction

  // Offer a frame until the model sees it captured, then scramble the parallel input.
  task automatic send(input logic [N-1:0][32:0] f);
    int c0, t;
    c0 = n_cap; t = 0;
    fmap = f; in_valid = 1'b1;
    while (n_cap == c0 && t < 500) begin step(); t++; end
    chk("capture_timeout", 64'(n_cap != c0), 64'd1);
    in_valid = 1'b0;
    fmap = rand_frame(30);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin step(); t++; end
    chk("drain_timeout", 64'(exp_q.size() == 0), 64'd1);
    step();
    step();
  endtask

  initial begin
    logic [N-1:0][32:0] f;
    int d0, c0, t;

    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step(); step();

    // Ramp frame, consumer always ready
    d0 = n_done_obs;
    send(ramp_frame());
    drain();
    chk("done_count_ramp", 64'(n_done_obs - d0), 64'd1);

    // Alternating backpressure with a long stall at idx 37
    rdy_mode = 1; stall_at = 37;
    send(ramp_frame());
    drain();
    rdy_mode = 0;

    // Back-to-back: second frame held on in_valid during the first
    d0 = n_done_obs;
    send(rand_frame(0));
    for (int i = 0; i < N; i++) f[i] = 33'h0_0000_0007;
    c0 = n_cap; t = 0;
    fmap = f; in_valid = 1'b1;
    while (n_cap == c0 && t < 500) begin step(); t++; end
    chk("b2b_capture", 64'(n_cap - c0), 64'd1);
    in_valid = 1'b0;
    drain();
    chk("done_count_b2b", 64'(n_done_obs - d0), 64'd2);

    // Reset in mid-frame, then a fresh frame restarts at element 0
    send(rand_frame(20));
    t = 0;
    while (exp_q.size() > 0 && exp_q[0].idx != 50 && t < 500) begin step(); t++; end
    chk("reach_idx50", 64'(exp_q.size() > 0), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step(); step();
    send(ramp_frame());
    drain();

    // Sparse and all-zero frames
    f = '0;
    f[3] = 33'd5;
    f[120] = {33{1'b1}};
    send(f);
    drain();
    d0 = n_done_obs;
    send('0);
    drain();
    chk("done_count_zero", 64'(n_done_obs - d0), 64'd1);

    // Randomized frames, random backpressure, some back-to-back
    rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      send(rand_frame(int'($urandom_range(0, 90))));
      if ($urandom_range(0, 1) == 1) drain();
      else for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
    end
    send(rand_frame(97));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
